dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 data cache controller between the MEM stage and

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_array.sv | 55 +++++
 rtl/dcache_ctrl.sv | 129 ++++++++++++
 tb/tb_dcache_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared widths, field positions and FSM encoding for the direct-mapped L1 data cache.
// Address layout: {tag, index, word select, byte offset}.
package dcache_pkg;

    localparam int NUM_LINES = 32;
    localparam int IDX_W     = $clog2(NUM_LINES);
    localparam int LINE_BITS = 256;
    localparam int WORD_W    = 32;
    localparam int SEL_W     = 3;
    localparam int OFF_W     = 5;
    localparam int ADDR_W    = 32;
    localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
    localparam int IDX_LSB   = OFF_W;
    localparam int TAG_LSB   = OFF_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, a word-write port for store
// hits and a line-write port for fills. Only valid/dirty are reset.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 ww_en,
    input  logic [IDX_W-1:0]     ww_idx,
    input  logic [SEL_W-1:0]     ww_sel,
    input  logic [WORD_W-1:0]    ww_data,
    input  logic                 lw_en,
    input  logic [IDX_W-1:0]     lw_idx,
    input  logic [TAG_W-1:0]     lw_tag,
    input  logic [LINE_BITS-1:0] lw_line
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    // A fill always wins; the controller never issues both writes in one cycle anyway.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (lw_en) begin
            valid_q[lw_idx] <= 1'b1;
            dirty_q[lw_idx] <= 1'b0;
        end else if (ww_en) begin
            dirty_q[ww_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (lw_en) begin
            tag_q[lw_idx]  <= lw_tag;
            data_q[lw_idx] <= lw_line;
        end else if (ww_en) begin
            data_q[ww_idx][{ww_sel, 5'd0} +: WORD_W] <= ww_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller: zero-latency hits,
// writeback/allocate line bursts on misses, stall back to the pipeline.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [WORD_W-1:0]    wdata_i,
    output logic [WORD_W-1:0]    rdata_o,
    output logic                 stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i,
    output logic [1:0]           dbg_state_o
);

    // Memory handshake: mem_req_o rises with the burst and stays high (with stable
    // mem_we_o/mem_addr_o/mem_wdata_o) until the cycle mem_ack_i pulses; mem_ack_i is
    // only looked at while a burst is outstanding.

    state_t               state_q, state_d;
    logic [TAG_W-1:0]     miss_tag_q;
    logic [IDX_W-1:0]     miss_idx_q;

    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     req_idx;
    logic [SEL_W-1:0]     req_sel;
    logic                 unused_addr_bits;

    logic [IDX_W-1:0]     rd_idx;
    logic                 rd_valid, rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_line;

    logic                 idle, hit, access_hit, miss_start;
    logic                 ww_en, lw_en;

    assign req_tag          = addr_i[ADDR_W-1:TAG_LSB];
    assign req_idx          = addr_i[TAG_LSB-1:IDX_LSB];
    assign req_sel          = addr_i[IDX_LSB-1:2];
    assign unused_addr_bits = ^addr_i[1:0];

    // Outside IDLE the array is addressed by the captured miss, not the live CPU address.
    assign idle       = (state_q == IDLE);
    assign rd_idx     = idle ? req_idx : miss_idx_q;
    assign hit        = rd_valid & (rd_tag == req_tag);
    assign access_hit = req_i & idle & hit;
    assign miss_start = req_i & idle & ~hit;
    assign ww_en      = access_hit & we_i;

    assign stall_o     = req_i & ~(idle & hit);
    assign rdata_o     = (access_hit & ~we_i) ? rd_line[{req_sel, 5'd0} +: WORD_W] : '0;
    assign dbg_state_o = state_q;

    dcache_array u_array (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .ww_en    (ww_en),
        .ww_idx   (req_idx),
        .ww_sel   (req_sel),
        .ww_data  (wdata_i),
        .lw_en    (lw_en),
        .lw_idx   (miss_idx_q),
        .lw_tag   (miss_tag_q),
        .lw_line  (mem_rdata_i)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                miss_tag_q <= req_tag;
                miss_idx_q <= req_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        lw_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_start) begin
                    state_d = (rd_valid & rd_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = line_addr(rd_tag, miss_idx_q);
                mem_wdata_o = rd_line;
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_req_o  = 1'b1;
                mem_addr_o = line_addr(miss_tag_q, miss_idx_q);
                if (mem_ack_i) begin
                    lw_en   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, reset/ack/req-drop sequences,
// and random accesses checked against an ideal-memory cache model.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_i, req_i, we_i;
    logic [31:0]  addr_i, wdata_i, rdata_o, mem_addr_o;
    logic         stall_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [255:0] mem_wdata_o, mem_rdata_i, rdata_model, garbage;
    logic         ack_model, ack_force;
    logic [1:0]   dbg_state_o;

    int total = 0;
    int bad   = 0;
    int mem_lat = 10;
    int mem_cnt;
    int tx_count = 0;

    logic [31:0] dmem    [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [32:0] act_q[$];
    logic [32:0] exp_q[$];

    logic        mv [32];
    logic        md [32];
    int          mt [32];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_stall;
        int          exp_tx;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[7];

    assign mem_ack_i   = ack_model | ack_force;
    assign mem_rdata_i = ack_force ? garbage : rdata_model;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .dbg_state_o (dbg_state_o)
    );

    function automatic logic [31:0] init_word(input int w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Slow memory: acks after mem_lat cycles of request; a request held through an ack
    // counts that ack cycle as its own first cycle.
    initial begin
        for (int i = 0; i < 1024; i++) dmem[i] = init_word(i);
        dmem[16]    = 32'h1111_2222;
        ack_model   = 1'b0;
        rdata_model = '0;
        mem_cnt     = 0;
        forever begin
            @(negedge clk);
            if (!rst_i || !mem_req_o) begin
                ack_model = 1'b0;
                mem_cnt   = 0;
            end else if (mem_cnt >= mem_lat) begin
                ack_model = 1'b1;
                tx_count++;
                act_q.push_back({mem_we_o, mem_addr_o});
                for (int k = 0; k < 8; k++) begin
                    if (mem_we_o) dmem[(mem_addr_o >> 2) + k] = mem_wdata_o[k*32 +: 32];
                    else rdata_model[k*32 +: 32] = dmem[(mem_addr_o >> 2) + k];
                end
                mem_cnt = 1;
            end else begin
                ack_model = 1'b0;
                mem_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input int lat, output int stalls, output logic [31:0] rd,
                             output int first_req, output int ntx);
        int cyc;
        int tx0;
        stalls    = 0;
        first_req = -1;
        rd        = '0;
        cyc       = 0;
        mem_lat   = lat;
        tx0       = tx_count;
        @(posedge clk); #1;
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
        forever begin
            @(negedge clk);
            if (!stall_o) begin
                rd = rdata_o;
                break;
            end
            stalls++;
            if (mem_req_o && first_req < 0) first_req = cyc;
            cyc++;
            if (cyc > 200) begin
                total++; bad++;
                $display("FAIL timeout addr=%0h: stall still high after %0d cycles, required low", addr, cyc);
                break;
            end
        end
        @(posedge clk); #1;
        req_i = 1'b0; we_i = 1'b0;
        ntx = tx_count - tx0;
    endtask

    task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input int lat);
        int idx, tag, w, st, fr, ntx, exp_stall, exp_tx;
        logic miss, dirty;
        logic [31:0] rd, exp_rd;
        idx   = int'(addr[9:5]);
        tag   = int'(addr >> 10);
        w     = int'(addr >> 2);
        miss  = !mv[idx] || (mt[idx] != tag);
        dirty = miss && mv[idx] && md[idx];
        exp_stall = !miss ? 0 : (dirty ? 2*lat + 2 : lat + 2);
        exp_tx    = !miss ? 0 : (dirty ? 2 : 1);
        exp_rd    = we ? 32'h0 : ref_mem[w];
        do_access(we, addr, wd, lat, st, rd, fr, ntx);
        check($sformatf("ref_stall_%0h", addr), 64'(st), 64'(exp_stall));
        check($sformatf("ref_tx_%0h", addr), 64'(ntx), 64'(exp_tx));
        check($sformatf("ref_rdata_%0h", addr), 64'(rd), 64'(exp_rd));
        mv[idx] = 1'b1;
        mt[idx] = tag;
        if (miss) md[idx] = 1'b0;
        if (we) begin
            md[idx] = 1'b1;
            ref_mem[w] = wd;
        end
    endtask

    initial begin
        int st, fr, ntx, tx0, waited, exp_tx;
        logic [31:0] rd;

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        ref_mem[16] = 32'h1111_2222;
        for (int i = 0; i < 32; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = 0; end
        rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        ack_force = 1'b0; garbage = {8{32'hBAD0_BAD0}};

        vecs[0] = '{1'b0, 32'h0000_0040, 32'h0,         10, 12, 1, 32'h1111_2222};
        vecs[1] = '{1'b0, 32'h0000_0044, 32'h0,         10,  0, 0, init_word(17)};
        vecs[2] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 10,  0, 0, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0440, 32'h0,         10, 22, 2, init_word(272)};
        vecs[4] = '{1'b0, 32'h0000_0040, 32'h0,          0,  2, 1, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 32'h0000_0080, 32'hCAFE_F00D,  3,  5, 1, 32'h0};
        vecs[6] = '{1'b0, 32'h0000_0080, 32'h0,          3,  0, 0, 32'hCAFE_F00D};
        exp_q.push_back({1'b0, 32'h40});
        exp_q.push_back({1'b1, 32'h40});
        exp_q.push_back({1'b0, 32'h440});
        exp_q.push_back({1'b0, 32'h40});
        exp_q.push_back({1'b0, 32'h80});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 64'(stall_o), 64'h0);
        check("rst_rdata", 64'(rdata_o), 64'h0);
        check("rst_mem_req", 64'(mem_req_o), 64'h0);
        check("rst_mem_we", 64'(mem_we_o), 64'h0);
        check("rst_mem_addr", 64'(mem_addr_o), 64'h0);
        check("rst_mem_wdata", 64'(|mem_wdata_o), 64'h0);
        check("rst_state", 64'(dbg_state_o), 64'h0);
        #1 rst_i = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat, st, rd, fr, ntx);
            check($sformatf("vec%0d_stall", i), 64'(st), 64'(vecs[i].exp_stall));
            check($sformatf("vec%0d_tx", i), 64'(ntx), 64'(vecs[i].exp_tx));
            check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
            if (vecs[i].exp_tx > 0) check($sformatf("vec%0d_req_rise", i), 64'(fr), 64'd1);
        end
        check("mem_log_len", 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            check($sformatf("mem_log%0d", i), 64'(act_q[i]), 64'(exp_q[i]));
        check("wb_word0", 64'(dmem[16]), 64'hDEAD_BEEF);

        // Stray ack while idle must change nothing.
        @(posedge clk); #1 ack_force = 1'b1;
        @(negedge clk);
        check("stray_ack_state", 64'(dbg_state_o), 64'h0);
        check("stray_ack_req", 64'(mem_req_o), 64'h0);
        @(posedge clk); #1 ack_force = 1'b0;
        do_access(1'b0, 32'h80, 32'h0, 3, st, rd, fr, ntx);
        check("stray_ack_hit_stall", 64'(st), 64'h0);
        check("stray_ack_hit_data", 64'(rd), 64'hCAFE_F00D);
        do_access(1'b0, 32'h40, 32'h0, 3, st, rd, fr, ntx);
        check("stray_ack_hit2_data", 64'(rd), 64'hDEAD_BEEF);

        // Reset in the middle of an ALLOCATE burst.
        mem_lat = 10;
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h840;
        @(negedge clk);
        check("mid_rst_stall", 64'(stall_o), 64'h1);
        @(negedge clk);
        check("mid_rst_alloc_state", 64'(dbg_state_o), 64'h2);
        check("mid_rst_alloc_req", 64'(mem_req_o), 64'h1);
        @(negedge clk);
        #1 rst_i = 1'b0;
        #1;
        check("mid_rst_req_drop", 64'(mem_req_o), 64'h0);
        check("mid_rst_state", 64'(dbg_state_o), 64'h0);
        req_i = 1'b0;
        @(posedge clk); #1 rst_i = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = dmem[i];
        for (int i = 0; i < 32; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
        ref_access(1'b0, 32'h440, 32'h0, 10);
        ref_access(1'b0, 32'h80, 32'h0, 2);

        // Random traffic over a few indexes and tags so hits, clean and dirty misses mix.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 5)
                | (32'($urandom_range(0, 7)) << 2);
            ref_access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 6));
        end

        // Dropping req_i mid-miss still completes the fill.
        exp_tx = (mv[0] && md[0]) ? 2 : 1;
        tx0 = tx_count;
        mem_lat = 4;
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'hC00;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 req_i = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while ((dbg_state_o != 2'd0 || mem_req_o) && waited < 100);
        check("drop_done", 64'(waited < 100), 64'h1);
        check("drop_tx", 64'(tx_count - tx0), 64'(exp_tx));
        mv[0] = 1'b1; mt[0] = 3; md[0] = 1'b0;
        ref_access(1'b0, 32'hC04, 32'h0, 4);
        ref_access(1'b0, 32'h000, 32'h0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
